// File: rtl/code_seq_gen.sv
// code_seq_gen: pulsed BPSK phase-code generator.
//
// On each accepted rising edge of i_sinc a code configuration is latched and
// emitted chip by chip as signed amplitude samples (+AMP for a 1 chip, -AMP for
// a 0 chip). Supports single code, complementary A/B alternation and CW.
//
// Ports:
//   i_clk        system clock
//   i_rst        synchronous reset, active-high
//   i_sinc       pulse sync level; rising edge starts a pulse
//   i_mode       0=code A, 1=alternate A/B, 2=CW, 3=off
//   i_code_a/b   codes, chip k taken from bit (numdig-1-k)
//   i_numdig     chips per pulse (1..MAX_DIG)
//   i_tb         clock cycles per chip (>=1)
//   o_signal     signed sample, 0 while idle
//   o_active     high for the numdig*tb cycles of a pulse
//   o_pulse_sel  code used by the current/last pulse (0=A, 1=B)
//   o_chip_idx   current chip index
//   o_done       strobe on the last cycle of a pulse
//   o_cfg_err    sticky: a start was rejected for bad configuration
//   o_overrun    sticky: a sync edge arrived while a pulse was running
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | output 0, waiting for a sync edge with a valid configuration
// RUN   | emitting chips from the shadow registers
module code_seq_gen #(
  parameter int DATA_W  = 16,
  parameter int MAX_DIG = 32,
  parameter int CNT_W   = 32,
  parameter logic signed [DATA_W-1:0] AMP = 16'sd8191
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_sinc,
  input  logic [1:0]               i_mode,
  input  logic [MAX_DIG-1:0]       i_code_a,
  input  logic [MAX_DIG-1:0]       i_code_b,
  input  logic [31:0]              i_numdig,
  input  logic [CNT_W-1:0]         i_tb,
  output logic signed [DATA_W-1:0] o_signal,
  output logic                     o_active,
  output logic                     o_pulse_sel,
  output logic [7:0]               o_chip_idx,
  output logic                     o_done,
  output logic                     o_cfg_err,
  output logic                     o_overrun
);

  localparam logic signed [DATA_W-1:0] AMP_NEG = -AMP;
  localparam logic [CNT_W-1:0]         CNT_ONE = CNT_W'(1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_nxt;

  logic               sinc_q;
  logic               start_edge;
  logic               cfg_bad;
  logic               mode_off;
  logic               accept;
  logic               chip_end;
  logic               last_cycle;
  logic [MAX_DIG-1:0] code_sel;
  logic [MAX_DIG-1:0] sh_code;
  logic [CNT_W-1:0]   tb_m1;
  logic [CNT_W-1:0]   tb_left;
  logic [31:0]        chips_left;
  logic [7:0]         chip_idx;
  logic               toggle;
  logic               pulse_sel;
  logic               cfg_err;
  logic               overrun;

  assign start_edge = i_sinc & ~sinc_q;
  assign mode_off   = (i_mode == 2'd3);
  assign cfg_bad    = (i_numdig == 32'd0) || (i_numdig > 32'(MAX_DIG)) ||
                      (i_tb == '0);

  // Both counters run down to zero; the pulse ends when both hit zero together.
  assign chip_end   = (tb_left == '0);
  assign last_cycle = chip_end && (chips_left == 32'd0);

  // CW is handled by loading all ones, so the datapath has a single output path.
  always_comb begin
    code_sel = i_code_a;
    if (i_mode == 2'd2)
      code_sel = {MAX_DIG{1'b1}};
    else if (i_mode == 2'd1 && toggle)
      code_sel = i_code_b;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    o_done    = 1'b0;
    case (state)
      IDLE: begin
        if (start_edge && !mode_off && !cfg_bad) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last_cycle) begin
          o_done    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sinc_q     <= 1'b0;
      sh_code    <= '0;
      tb_m1      <= '0;
      tb_left    <= '0;
      chips_left <= '0;
      chip_idx   <= '0;
      toggle     <= 1'b0;
      pulse_sel  <= 1'b0;
      cfg_err    <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      sinc_q <= i_sinc;

      if (state == IDLE && start_edge && !mode_off && cfg_bad)
        cfg_err <= 1'b1;
      if (state == RUN && start_edge)
        overrun <= 1'b1;

      if (accept) begin
        // Left-align the code so chip 0 sits in the MSB; each chip shifts left.
        sh_code    <= code_sel << (32'(MAX_DIG) - i_numdig);
        tb_m1      <= i_tb - CNT_ONE;
        tb_left    <= i_tb - CNT_ONE;
        chips_left <= i_numdig - 32'd1;
        chip_idx   <= '0;
        if (i_mode == 2'd1) begin
          pulse_sel <= toggle;
          toggle    <= ~toggle;
        end else begin
          pulse_sel <= 1'b0;
          toggle    <= 1'b0;
        end
      end else if (state == RUN) begin
        if (last_cycle) begin
          chip_idx <= '0;
        end else if (chip_end) begin
          tb_left    <= tb_m1;
          chips_left <= chips_left - 32'd1;
          chip_idx   <= chip_idx + 8'd1;
          sh_code    <= {sh_code[MAX_DIG-2:0], 1'b0};
        end else begin
          tb_left <= tb_left - CNT_ONE;
        end
      end
    end
  end

  assign o_signal    = (state == RUN) ? (sh_code[MAX_DIG-1] ? AMP : AMP_NEG) : '0;
  assign o_active    = (state == RUN);
  assign o_pulse_sel = pulse_sel;
  assign o_chip_idx  = chip_idx;
  assign o_cfg_err   = cfg_err;
  assign o_overrun   = overrun;

endmodule
